div_hilo_unit: RTL and testbench

Sequencer between the control unit and the iterative divider. It accepts DIV/DIVU requests, handles sign conversion around the unsigned divider core, detects a zero divisor itself, launches the core with a single start pulse, waits for its done flag, and commits results to the architectural HI/LO registers. It also services MTHI/MTLO writes and supplies HI/LO for MFHI/MFLO.

---
 rtl/div_hilo_unit_pkg.sv | 24 ++
 rtl/div_hilo_unit_sign_fix.sv | 27 ++
 rtl/div_hilo_unit.sv | 223 ++++++++++++++++++++++
 tb/tb_div_hilo_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_hilo_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_hilo_unit_pkg
// Shared definitions for the HI/LO division sequencer.
//   - DefaultWidth : default operand/result width
//   - IntMin       : most negative value at the default width
//   - div_state_e  : sequencer FSM state encoding
// -----------------------------------------------------------------------------
package div_hilo_unit_pkg;

   localparam int unsigned DefaultWidth = 32;

   // Magnitude of this value is itself when read as unsigned.
   localparam logic [DefaultWidth-1:0] IntMin = {1'b1, {(DefaultWidth-1){1'b0}}};

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StZero   = 3'd1,
      StLaunch = 3'd2,
      StGuard  = 3'd3,
      StWait   = 3'd4,
      StFix    = 3'd5
   } div_state_e;

endpackage

// File: rtl/div_hilo_unit_sign_fix.sv
// -----------------------------------------------------------------------------
// div_sign_fix
// Combinational conditional two's-complement negation (modulo 2^WIDTH).
// Used both for operand magnitude extraction and for result sign correction.
// Ports:
//   value  in  WIDTH  input operand
//   negate in  1      1 = output -value, 0 = pass through
//   result out WIDTH  conditioned value
// -----------------------------------------------------------------------------
module div_sign_fix
   import div_hilo_unit_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic [WIDTH-1:0] value,
   input  logic             negate,
   output logic [WIDTH-1:0] result
);

   always_comb begin
      result = value;
      if (negate) begin
         result = ~value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/div_hilo_unit.sv
// -----------------------------------------------------------------------------
// div_hilo_unit
// Sequencer between the control unit and an iterative unsigned divider core.
// Converts signed operands to magnitudes, traps a zero divisor locally, launches
// the core with a single start pulse, waits for its done flag, corrects result
// signs and commits LO = quotient, HI = remainder. Also services MTHI/MTLO.
//
// Optional feature: define DIV_TIMEOUT_EN to add a WAIT-cycle watchdog that
// aborts the operation after TIMEOUT_CYCLES and pulses exc_timeout.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   op_valid/op_signed  division request, 1 = DIV, 0 = DIVU
//   op_a, op_b          dividend, divisor
//   busy                unit occupied (requests ignored)
//   op_done             one-cycle pulse on commit or abort
//   exc_div_zero        one-cycle pulse, divisor was zero
//   div_start/a/b       core launch pulse and operand magnitudes
//   div_quotient/remainder/done  core results
//   hi_we, lo_we, hilo_wdata     MTHI/MTLO write port
//   hi, lo              architectural HI/LO registers
//   exc_timeout         (DIV_TIMEOUT_EN only) watchdog abort pulse
// -----------------------------------------------------------------------------
module div_hilo_unit
   import div_hilo_unit_pkg::*;
#(
   parameter int unsigned WIDTH          = DefaultWidth,
   parameter int unsigned TIMEOUT_CYCLES = 40
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   input  logic             op_signed,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             op_done,
   output logic             exc_div_zero,
   output logic             div_start,
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   input  logic [WIDTH-1:0] div_quotient,
   input  logic [WIDTH-1:0] div_remainder,
   input  logic             div_done,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] hilo_wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
`ifdef DIV_TIMEOUT_EN
   ,
   output logic             exc_timeout
`endif
);

   div_state_e state_q, state_d;

   logic [WIDTH-1:0] a_mag_q, b_mag_q;
   logic [WIDTH-1:0] quo_q, rem_q;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             neg_quo_q, neg_rem_q;

   logic             capture, latch, commit;
   logic [WIDTH-1:0] a_mag, b_mag, quo_fix, rem_fix;
   logic             a_neg, b_neg;

   assign a_neg = op_signed & op_a[WIDTH-1];
   assign b_neg = op_signed & op_b[WIDTH-1];

   div_sign_fix #(.WIDTH(WIDTH)) u_fix_a (
      .value  (op_a),
      .negate (a_neg),
      .result (a_mag)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_fix_b (
      .value  (op_b),
      .negate (b_neg),
      .result (b_mag)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_fix_quo (
      .value  (quo_q),
      .negate (neg_quo_q),
      .result (quo_fix)
   );

   div_sign_fix #(.WIDTH(WIDTH)) u_fix_rem (
      .value  (rem_q),
      .negate (neg_rem_q),
      .result (rem_fix)
   );

`ifdef DIV_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout;

   assign timeout = (state_q == StWait) && !div_done &&
                    (wait_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_cnt_d = '0;
      if (state_q == StWait) begin
         wait_cnt_d = wait_cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   assign exc_timeout = timeout;
`endif

   // Next-state and decoded strobes.
   always_comb begin
      state_d      = state_q;
      capture      = 1'b0;
      latch        = 1'b0;
      commit       = 1'b0;
      div_start    = 1'b0;
      op_done      = 1'b0;
      exc_div_zero = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (op_valid) begin
               capture = 1'b1;
               state_d = (op_b == '0) ? StZero : StLaunch;
            end
         end
         StZero: begin
            op_done      = 1'b1;
            exc_div_zero = 1'b1;
            state_d      = StIdle;
         end
         StLaunch: begin
            div_start = 1'b1;
            state_d   = StGuard;
         end
         // The core may still present done from the previous op here.
         StGuard: begin
            state_d = StWait;
         end
         StWait: begin
            if (div_done) begin
               latch   = 1'b1;
               state_d = StFix;
            end
`ifdef DIV_TIMEOUT_EN
            else if (timeout) begin
               op_done = 1'b1;
               state_d = StIdle;
            end
`endif
         end
         StFix: begin
            commit  = 1'b1;
            op_done = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // MTHI/MTLO first, division commit overrides in the same cycle.
   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (hi_we) begin
         hi_d = hilo_wdata;
      end
      if (lo_we) begin
         lo_d = hilo_wdata;
      end
      if (commit) begin
         hi_d = rem_fix;
         lo_d = quo_fix;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_mag_q   <= '0;
         b_mag_q   <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         quo_q     <= '0;
         rem_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         if (capture) begin
            a_mag_q   <= a_mag;
            b_mag_q   <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
         end
         if (latch) begin
            quo_q <= div_quotient;
            rem_q <= div_remainder;
         end
      end
   end

   assign busy  = (state_q != StIdle);
   assign div_a = a_mag_q;
   assign div_b = b_mag_q;
   assign hi    = hi_q;
   assign lo    = lo_q;

endmodule

// File: tb/tb_div_hilo_unit.sv
module tb_div_hilo_unit;
   import div_hilo_unit_pkg::*;

   localparam int unsigned W       = 32;
   localparam int          CoreLat = 6;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         zero;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
   } start_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         op_valid = 1'b0, op_signed = 1'b0;
   logic [W-1:0] op_a = '0, op_b = '0;
   logic         busy, op_done, exc_div_zero, div_start;
   logic [W-1:0] div_a, div_b;
   logic [W-1:0] div_quotient, div_remainder;
   logic         div_done;
   logic         hi_we = 1'b0, lo_we = 1'b0;
   logic [W-1:0] hilo_wdata = '0;
   logic [W-1:0] hi, lo;
`ifdef DIV_TIMEOUT_EN
   logic         exc_timeout;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   exp_t   expq[$];
   start_t startq[$];

   always #5 clk = ~clk;

   div_hilo_unit #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op_valid      (op_valid),
      .op_signed     (op_signed),
      .op_a          (op_a),
      .op_b          (op_b),
      .busy          (busy),
      .op_done       (op_done),
      .exc_div_zero  (exc_div_zero),
      .div_start     (div_start),
      .div_a         (div_a),
      .div_b         (div_b),
      .div_quotient  (div_quotient),
      .div_remainder (div_remainder),
      .div_done      (div_done),
      .hi_we         (hi_we),
      .lo_we         (lo_we),
      .hilo_wdata    (hilo_wdata),
      .hi            (hi),
      .lo            (lo)
`ifdef DIV_TIMEOUT_EN
      ,
      .exc_timeout   (exc_timeout)
`endif
   );

   // Divider core model: done (with old results) stays visible through the
   // LAUNCH and GUARD cycles, then drops, then rises CoreLat-ish cycles later.
   logic [W-1:0] core_a, core_b;
   int           core_cnt;
   logic         clear_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_done      <= 1'b0;
         div_quotient  <= '0;
         div_remainder <= '0;
         core_cnt      <= 0;
         clear_pend    <= 1'b0;
         core_a        <= '0;
         core_b        <= '0;
      end else if (div_start) begin
         core_a     <= div_a;
         core_b     <= div_b;
         core_cnt   <= CoreLat;
         clear_pend <= 1'b1;
      end else begin
         if (clear_pend) begin
            div_done   <= 1'b0;
            clear_pend <= 1'b0;
         end
         if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
               div_done      <= 1'b1;
               div_quotient  <= core_a / core_b;
               div_remainder <= core_a % core_b;
            end
         end
      end
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Launch monitor: every div_start must match a queued operand pair.
   always @(negedge clk) begin
      if (rst_n && div_start) begin
         if (startq.size() == 0) begin
            check("unexpected_div_start", 32'd1, 32'd0);
         end else begin
            start_t s;
            s = startq.pop_front();
            check("div_a", div_a, s.a);
            check("div_b", div_b, s.b);
         end
      end
   end

   // Completion monitor: exception flag at op_done, HI/LO one cycle later.
   always begin
      @(negedge clk);
      if (rst_n && op_done) begin
         if (expq.size() == 0) begin
            check("unexpected_op_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            check("exc_div_zero", {31'd0, exc_div_zero}, {31'd0, e.zero});
            @(negedge clk);
            check("lo", lo, e.lo);
            check("hi", hi, e.hi);
         end
      end
   end

   task automatic wait_not_busy();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("busy_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi);
      exp_t e;
      start_t s;
      wait_not_busy();
      e.lo   = elo;
      e.hi   = ehi;
      e.zero = (b == '0);
      expq.push_back(e);
      if (b != '0) begin
         s.a = ma;
         s.b = mb;
         startq.push_back(s);
      end
      op_valid  = 1'b1;
      op_signed = sgn;
      op_a      = a;
      op_b      = b;
      @(negedge clk);
      op_valid  = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((busy || expq.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (expq.size() != 0) check("op_done_missing", expq.size(), 32'd0);
      check("busy_after_op", {31'd0, busy}, 32'd0);
   endtask

   task automatic mt_write(input logic h, input logic l, input logic [W-1:0] d);
      hi_we      = h;
      lo_we      = l;
      hilo_wdata = d;
      @(negedge clk);
      hi_we      = 1'b0;
      lo_we      = 1'b0;
   endtask

   initial begin
      int n;
      logic [W-1:0] int_min;
      int_min = IntMin;

      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_op_done", {31'd0, op_done}, 32'd0);
      check("rst_div_start", {31'd0, div_start}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      mt_write(1'b1, 1'b1, 32'h33);
      check("mt_both_hi", hi, 32'h33);
      check("mt_both_lo", lo, 32'h33);

      issue(1'b0, 32'd100, 32'd7, 32'd100, 32'd7, 32'd14, 32'd2);
      drain();
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
      drain();
      issue(1'b0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
      drain();
      issue(1'b1, int_min, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0);
      drain();
      issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2, 32'hFFFF_FFFD, 32'd1);
      drain();
      issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd7, 32'd2, 32'd3, 32'hFFFF_FFFF);
      drain();

      // Zero divisor with preloaded HI/LO.
      mt_write(1'b1, 1'b0, 32'h11);
      mt_write(1'b0, 1'b1, 32'h22);
      issue(1'b1, 32'd5, 32'd0, 32'd0, 32'd0, 32'h22, 32'h11);
      check("zero_pulse_cycle", {31'd0, exc_div_zero}, 32'd1);
      drain();

      // Back-to-back: stale done from the first op while the second launches.
      issue(1'b0, 32'd50, 32'd6, 32'd50, 32'd6, 32'd8, 32'd2);
      issue(1'b0, 32'd9, 32'd4, 32'd9, 32'd4, 32'd2, 32'd1);
      repeat (3) @(negedge clk);
      mt_write(1'b1, 1'b0, 32'h77);
      n = 0;
      while (!op_done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!op_done) check("fix_wait_timeout", 32'd1, 32'd0);
      lo_we      = 1'b1;
      hilo_wdata = 32'h55;
      @(negedge clk);
      lo_we      = 1'b0;
      drain();

      // Reset while waiting on the core.
      issue(1'b0, 32'd1000, 32'd3, 32'd1000, 32'd3, 32'd333, 32'd1);
      repeat (4) @(negedge clk);
      check("pre_reset_busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      expq.delete();
      startq.delete();
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_op_done", {31'd0, op_done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(1'b0, 32'd1000, 32'd3, 32'd1000, 32'd3, 32'd333, 32'd1);
      drain();

      if (startq.size() != 0) check("div_start_missing", startq.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
